canny_sobel_grad: RTL
=====================

# canny_sobel_grad

Sobel gradient stage of the Canny edge pipeline, directly downstream of the three-row line buffer. It consumes the three vertically aligned row taps per pixel and builds a 3x3 window with column shift registers. It computes Gx/Gy, the L1 gradient magnitude and a 2-bit quantised direction, and hands the results to non-maximum suppression. Output is one result per accepted input pixel, with a fixed pipeline latency and no back-pressure.

## Interface
- DATA_WIDTH, 8, pixel width of each tap
- IMG_WIDTH, 640, pixels per line
- IMG_HEIGHT, 480, lines per frame
- MAG_WIDTH, DATA_WIDTH+3, magnitude width (max 8*(2^DATA_WIDTH-1))
- clock  in  1  sole clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- clken  in  1  pixel-accept strobe, same strobe that drives the line buffer
- taps0x  in  DATA_WIDTH  newest row (bottom of window)
- taps1x  in  DATA_WIDTH  middle row
- taps2x  in  DATA_WIDTH  oldest row (top of window)
- out_valid  out  1  result strobe
- out_mag  out  MAG_WIDTH  |Gx|+|Gy|, unsigned
- out_dir  out  2  0=0°, 1=45°, 2=90°, 3=135°
- out_border  out  1  window incomplete (image edge)

## Operation
- Taps are valid the cycle after clken. Internal tap_vld = clken delayed by 1. Taps are sampled only when tap_vld=1.
- Window: three columns x three rows, p[r][c], with r=0 top (taps2x) and c=0 oldest. It shifts left by one column on tap_vld and holds otherwise.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance on tap_vld.
  - col wraps to 0 and row increments at col=IMG_WIDTH-1.
  - At the last pixel of the frame, both wrap to 0.
- Gx = (p02+2p12+p22) − (p00+2p10+p20).
- Gy = (p20+2p21+p22) − (p00+2p01+p02).
- Both are signed, DATA_WIDTH+3 bits, and cannot overflow.
- Magnitude: |Gx|+|Gy|, exact in MAG_WIDTH, no saturation.
- Direction, with ax=|Gx| and ay=|Gy|:
  - ax=ay=0 → 0.
  - 5·ay < 2·ax → 0.
  - 2·ay > 5·ax → 2.
  - Otherwise sign(Gx)==sign(Gy) → 1, else 3. Zero counts as positive.
- Border: out_border=1 when the col or row counter value at the sampling tap_vld is <2.
  - When out_border=1, out_mag=0 and out_dir=0.
- clken gaps: the window and counters freeze, and the valid pipeline drains normally. No bubbles are inserted into the data.

## Timing
- Stage 1 (tap_vld): window shift plus counter update.
- Stage 2: Gx/Gy sums.
- Stage 3: abs, magnitude, direction and border mask, registered to the outputs.
- Latency: out_valid is asserted exactly 4 cycles after the corresponding clken (3 after tap_vld), one pulse per clken pulse.
- Outputs change only when out_valid rises.
- Reset: all outputs go to 0 the cycle after rst is sampled high. Counters, window, tap_vld and the valid pipeline are cleared.
  - clken that is high while rst=1 is ignored.
  - Reset mid-frame restarts at row 0, col 0.
- Back-to-back clken gives full throughput of 1 result per cycle.

## Configuration
- CANNY_SOBEL_DIR_EN defined: the direction quantiser is built, and out_dir follows the rules above.
- CANNY_SOBEL_DIR_EN undefined: the quantiser is omitted and out_dir is tied to 0. Magnitude, border and latency are unchanged.

## Structure
- Package canny_pkg holds:
  - Direction codes DIR_0, DIR_45, DIR_90, DIR_135.
  - Quantiser constants TAN_NUM=2 and TAN_DEN=5.
  - Function for derived width MAG_WIDTH.
- One sub-module, canny_dir_quant: combinational ax, ay, sign bits → 2-bit code. It is instantiated only under CANNY_SOBEL_DIR_EN.

## Test plan
- Flat image, all pixels 100, full 640x480 frame → every non-border out_mag=0, out_dir=0; 307200 out_valid pulses.
- Vertical step (cols <320 = 0, ≥320 = 255) → at the columns straddling the step: Gx=1020, out_mag=1020, out_dir=0.
- Horizontal step (rows <240 = 0, ≥240 = 255) → at the rows straddling the step: Gy=1020, out_mag=1020, out_dir=2. Values are symmetric with the vertical case.
- Diagonal ramp p=x+y → Gx=Gy=8, out_mag=16, out_dir=1. Ramp p=x−y+255 → out_dir=3.
- Border and latency: single clken pulses with random gaps → out_valid exactly 4 cycles after each pulse. The first two rows and first two columns give out_border=1 and out_mag=0.
- Reset at row 100, col 50 mid-frame → outputs 0 the next cycle. Restarted stream gives out_border=1 for rows 0–1, proving the counters cleared.

Source files
------------

// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny Sobel gradient stage.
package canny_pkg;

  typedef enum logic [1:0] {
    DIR_0   = 2'd0,
    DIR_45  = 2'd1,
    DIR_90  = 2'd2,
    DIR_135 = 2'd3
  } dir_e;

  // tan(22.5 deg) approximated as TAN_NUM/TAN_DEN
  localparam int TAN_NUM = 2;
  localparam int TAN_DEN = 5;

  // |Gx|+|Gy| peaks at 8*(2^dw-1)
  function automatic int mag_width(input int dw);
    return dw + 3;
  endfunction

endpackage

// File: rtl/canny_dir_quant.sv
// Combinational gradient direction quantiser: |Gx|, |Gy| and signs to a 2-bit code.
module canny_dir_quant
  import canny_pkg::*;
#(
  parameter int W = 11
) (
  input  logic [W-1:0] ax,
  input  logic [W-1:0] ay,
  input  logic         sx,
  input  logic         sy,
  output dir_e         dir
);

  localparam int PW = W + 3;

  logic [PW-1:0] ax_num, ax_den, ay_num, ay_den;

  assign ax_num = PW'(ax) * PW'(TAN_NUM);
  assign ax_den = PW'(ax) * PW'(TAN_DEN);
  assign ay_num = PW'(ay) * PW'(TAN_NUM);
  assign ay_den = PW'(ay) * PW'(TAN_DEN);

  always_comb begin
    dir = DIR_0;
    if (ax == '0 && ay == '0)  dir = DIR_0;
    else if (ay_den < ax_num)  dir = DIR_0;
    else if (ay_num > ax_den)  dir = DIR_90;
    // sign bits: zero is treated as positive
    else                       dir = (sx == sy) ? DIR_45 : DIR_135;
  end

endmodule

// File: rtl/canny_sobel_grad.sv
// Sobel gradient stage: 3x3 window, Gx/Gy, L1 magnitude, quantised direction.
// Direction quantiser is built only with CANNY_SOBEL_DIR_EN; otherwise out_dir is 0.
module canny_sobel_grad
  import canny_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int MAG_WIDTH  = mag_width(DATA_WIDTH)
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  clken,
  input  logic [DATA_WIDTH-1:0] taps0x,
  input  logic [DATA_WIDTH-1:0] taps1x,
  input  logic [DATA_WIDTH-1:0] taps2x,
  output logic                  out_valid,
  output logic [MAG_WIDTH-1:0]  out_mag,
  output logic [1:0]            out_dir,
  output logic                  out_border
);

  localparam int SW = DATA_WIDTH + 2;
  localparam int GW = DATA_WIDTH + 3;
  localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
  localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;

  // [0]=tap_vld, [1]=window, [2]=sums, [3]=outputs
  logic [3:0] vld_pipe;
  logic       tap_vld;

  logic [2:0][2:0][DATA_WIDTH-1:0] win;  // win[row][col], row 0 = top, col 0 = oldest
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          brd1, brd2;

  logic [SW-1:0]        sum_l, sum_r, sum_t, sum_b;
  logic signed [GW-1:0] gx_q, gy_q;
  logic [GW-1:0]        ax, ay;
  logic [MAG_WIDTH-1:0] mag;
  dir_e                 dir_c;

  assign tap_vld   = vld_pipe[0];
  assign out_valid = vld_pipe[3];

  always_ff @(posedge clock) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[2:0], clken};
  end

  // Stage 1: window shift and position counters
  always_ff @(posedge clock) begin
    if (rst) begin
      win  <= '0;
      col  <= '0;
      row  <= '0;
      brd1 <= 1'b0;
    end else if (tap_vld) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= taps2x;
      win[1][2] <= taps1x;
      win[2][2] <= taps0x;
      brd1 <= (col < CW'(2)) || (row < RW'(2));
      if (col == CW'(IMG_WIDTH - 1)) begin
        col <= '0;
        row <= (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Stage 2: weighted column/row sums
  always_comb begin
    sum_l = SW'(win[0][0]) + SW'({win[1][0], 1'b0}) + SW'(win[2][0]);
    sum_r = SW'(win[0][2]) + SW'({win[1][2], 1'b0}) + SW'(win[2][2]);
    sum_t = SW'(win[0][0]) + SW'({win[0][1], 1'b0}) + SW'(win[0][2]);
    sum_b = SW'(win[2][0]) + SW'({win[2][1], 1'b0}) + SW'(win[2][2]);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      gx_q <= '0;
      gy_q <= '0;
      brd2 <= 1'b0;
    end else if (vld_pipe[1]) begin
      gx_q <= $signed({1'b0, sum_r}) - $signed({1'b0, sum_l});
      gy_q <= $signed({1'b0, sum_b}) - $signed({1'b0, sum_t});
      brd2 <= brd1;
    end
  end

  // Stage 3: abs, magnitude, direction, border mask
  assign ax  = gx_q[GW-1] ? unsigned'(-gx_q) : unsigned'(gx_q);
  assign ay  = gy_q[GW-1] ? unsigned'(-gy_q) : unsigned'(gy_q);
  assign mag = MAG_WIDTH'(ax) + MAG_WIDTH'(ay);

`ifdef CANNY_SOBEL_DIR_EN
  canny_dir_quant #(.W(GW)) u_dir_quant (
    .ax  (ax),
    .ay  (ay),
    .sx  (gx_q[GW-1]),
    .sy  (gy_q[GW-1]),
    .dir (dir_c)
  );
`else
  assign dir_c = DIR_0;
`endif

  always_ff @(posedge clock) begin
    if (rst) begin
      out_mag    <= '0;
      out_dir    <= DIR_0;
      out_border <= 1'b0;
    end else if (vld_pipe[2]) begin
      out_mag    <= brd2 ? '0 : mag;
      out_dir    <= brd2 ? DIR_0 : dir_c;
      out_border <= brd2;
    end
  end

endmodule
